// File: rtl/debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_pkg
//   Shared definitions for the push-button debouncer:
//     - db_state_e               : 2-bit FSM state encoding (all four codes used)
//     - DEBOUNCE_CYCLES_DEFAULT  : default stable-cycle count (1 ms at 50 MHz)
//     - db_is_check()            : true while a candidate level is being timed
// -----------------------------------------------------------------------------
package debouncer_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    CHECK_LOW   = 2'b11
  } db_state_e;

  function automatic logic db_is_check(input db_state_e st);
    return (st == CHECK_HIGH) || (st == CHECK_LOW);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     i_clk   : destination clock
//     i_rst_n : asynchronous active-low reset, clears both flops to 0
//     i_d     : asynchronous input bit
//     o_q     : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Debounces a mechanical push-button. A level change is accepted only after
//   the sampled input has held the new level for DEBOUNCE_CYCLES consecutive
//   clock cycles past the edge that first saw it (DEBOUNCE_CYCLES+1 edges in
//   total, counting that first edge).
//
//   Build option:
//     DEBOUNCER_SYNC_EN : when defined, btn_raw passes through a two-flop
//                         synchronizer (sync_2ff) first, adding 2 cycles of
//                         latency. When undefined, btn_raw must already be
//                         synchronous to clk.
//
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles required, legal range 2 .. 2**24
//   Ports:
//     clk     : system clock, rising edge
//     rst     : asynchronous active-low reset
//     btn_raw : raw (bouncing) button level
//     btn     : debounced level, straight from a flop
//     busy    : high while a candidate level change is being timed
// -----------------------------------------------------------------------------
module button_debouncer
  import debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_btn;

  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_btn_nxt;
  logic             w_busy;
  logic             w_s;

  // Sampled input
`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (btn_raw),
    .o_q     (w_s)
  );
`else
  assign w_s = btn_raw;
`endif

  // State, counter and debounced-level registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_btn   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_btn   <= w_btn_nxt;
    end
  end

  // Next-state logic. The counter only runs in the CHECK states; it tops out
  // at CNT_LAST, where the commit happens instead of an increment, so it never
  // wraps. btn changes on the very edge that commits the new level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_btn_nxt   = r_btn;
    case (r_state)
      STABLE_LOW: begin
        w_cnt_nxt = '0;
        if (w_s) begin
          w_state_nxt = CHECK_HIGH;
        end
      end
      CHECK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
          w_btn_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        w_cnt_nxt = '0;
        if (!w_s) begin
          w_state_nxt = CHECK_LOW;
        end
      end
      CHECK_LOW: begin
        if (w_s) begin
          w_state_nxt = STABLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LOW;
          w_cnt_nxt   = '0;
          w_btn_nxt   = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      // Unreachable with a fully used 2-bit encoding; kept so any corrupted
      // state falls back to the reset condition.
      default: begin
        w_state_nxt = STABLE_LOW;
        w_cnt_nxt   = '0;
        w_btn_nxt   = 1'b0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    w_busy = db_is_check(r_state);
  end

  assign busy = w_busy;
  assign btn  = r_btn;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 4.
//   The reference model tracks only the accepted level and the length of the
//   current run of samples that disagree with it: once that run reaches
//   DEBOUNCE_CYCLES+1 samples the level flips. busy is "a run is in progress".
//   Define DEBOUNCER_SYNC_EN for both bench and RTL to cover the synchronizer.
// -----------------------------------------------------------------------------
module tb_button_debouncer;
  import debouncer_pkg::*;

  localparam int D = 4;
`ifdef DEBOUNCER_SYNC_EN
  localparam int LAT = D + 1 + 2;
`else
  localparam int LAT = D + 1;
`endif

  logic clk;
  logic rst;
  logic btn_raw;
  logic btn;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_btn;
  int         m_run;
  logic [1:0] m_sync;

  button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .btn     (btn),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_btn  = 1'b0;
    m_run  = 0;
    m_sync = 2'b00;
  endtask

  task automatic model_edge(input logic raw);
    logic s;
`ifdef DEBOUNCER_SYNC_EN
    s      = m_sync[1];
    m_sync = {m_sync[0], raw};
`else
    s      = raw;
`endif
    if (s != m_btn) begin
      m_run++;
      if (m_run == D + 1) begin
        m_btn = s;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One clock cycle: drive on the falling edge, check 1 time unit after the
  // rising edge.
  task automatic cyc(input logic raw, input logic rstv, input string tag);
    @(negedge clk);
    btn_raw = raw;
    rst     = rstv;
    if (!rstv) model_reset();
    @(posedge clk);
    #1;
    if (rstv) model_edge(raw);
    check({tag, "_btn"},  {31'd0, btn},  {31'd0, m_btn});
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_run > 0)});
  endtask

  task automatic settle(input logic lvl);
    for (int i = 0; i < LAT + 2; i++) cyc(lvl, 1'b1, "settle");
  endtask

  // Applies pat[0..len-1] one bit per cycle; reports the 1-based step at which
  // btn first left its starting level (0 if never) and the busy cycle count.
  task automatic run_pat(input string tag, input logic [31:0] pat, input int len,
                         output int flip_at, output int busy_cnt);
    logic start;
    start    = m_btn;
    flip_at  = 0;
    busy_cnt = 0;
    for (int i = 0; i < len; i++) begin
      cyc(pat[i], 1'b1, tag);
      if (busy) busy_cnt++;
      if (flip_at == 0 && btn != start) flip_at = i + 1;
    end
  endtask

  initial begin
    int flip_at;
    int busy_cnt;
    logic lvl;
    int run_len;
    logic rstv;

    rst     = 1'b0;
    btn_raw = 1'b0;
    model_reset();
    #1;
    check("reset_btn",  {31'd0, btn},  32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) cyc(1'b0, 1'b0, "in_reset");
    settle(1'b0);

    // Clean press
    run_pat("clean", 32'h0000_0FFF, 12, flip_at, busy_cnt);
    check("clean_rise_edge", flip_at, LAT);
    check("clean_busy_cycles", busy_cnt, D);

    // Clean release
    run_pat("clean_rel", 32'h0000_0000, 12, flip_at, busy_cnt);
    check("clean_fall_edge", flip_at, LAT);
    settle(1'b0);

    // Press bounce 1,0,1,1,0,1,1,1,1,1,...
    run_pat("bounce", 32'h0000_3FED, 14, flip_at, busy_cnt);
    check("bounce_rise_edge", flip_at, 5 + LAT);
    settle(1'b1);

    // Release bounce 0,1,0,0,0,0,...
    run_pat("rel_bounce", 32'h0000_0002, 12, flip_at, busy_cnt);
    check("rel_bounce_fall_edge", flip_at, 2 + LAT);
    settle(1'b0);

    // Single-cycle glitch
    run_pat("glitch", 32'h0000_0001, 10, flip_at, busy_cnt);
    check("glitch_no_rise", flip_at, 0);
    check("glitch_busy_cycles", busy_cnt, 1);

    // Reset in the middle of a check (counter at 2)
    settle(1'b0);
    for (int i = 0; i < LAT - 2; i++) cyc(1'b1, 1'b1, "pre_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_btn",   {31'd0, btn},  32'd0);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_state", {30'd0, dut.r_state}, {30'd0, STABLE_LOW});
    repeat (3) cyc(1'b1, 1'b0, "held_rst");
    run_pat("post_rst", 32'h0000_FFFF, 12, flip_at, busy_cnt);
    check("post_rst_rise_edge", flip_at, LAT);
    check("post_rst_busy_cycles", busy_cnt, D);

    // Randomized runs with occasional reset pulses
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      lvl     = ~lvl;
      run_len = $urandom_range(1, 2 * D + 4);
      for (int k = 0; k < run_len; k++) begin
        rstv = ($urandom_range(0, 79) != 0);
        cyc(lvl, rstv, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
